seg_scan_capture: RTL
=====================

# seg_scan_capture

Monitor-side receiver for the 4-digit multiplexed seven-segment display bus. It samples the `disp`/`mux` lines our display driver produces and reconstructs the four hex digits being shown. It reports each digit set only after the same set has been seen over consecutive full scans. It sits in self-check and loopback builds alongside the display driver, where it turns the scanned display back into nibbles for compare logic or a bench.

## Interface
- `SETTLE`, default 4: consecutive identical registered cycles required before a digit is sampled; legal range 1–255.
- `STABLE_FRAMES`, default 2: consecutive identical complete frames required before `digits` updates; legal range 1–15.
- `SEG_ACTIVE_LOW`, default 1: 1 means a segment line is lit when 0.
- `POS_ACTIVE_LOW`, default 1: 1 means a `mux` line selects its digit when 0.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `disp` in 7: segment lines, bit0 = a … bit6 = g.
- `mux` in 4: digit-select lines; bit i selects digit i.
- `digits` out 16: {d3,d2,d1,d0}; d_i is the nibble shown while `mux` bit i is active.
- `digits_valid` out 1: level; set by the first `digits` update and stays set until reset.
- `frame_done` out 1: one-cycle pulse per completed error-free frame.
- `bad_pattern` out 1: one-cycle pulse when a sampled segment pattern is not a legal glyph.

## Operation
- **Input register and normalization:** `disp` and `mux` are registered once. They are then normalized to active-high using the two polarity parameters.
- **Position decode:** exactly one normalized `mux` bit set gives position p = its index. Zero bits or more than one bit set is a blank position and is ignored.
- **States:**
  - WAIT: the position is blank. Move to SETTLE when a valid position appears.
  - SETTLE: count consecutive cycles in which the normalized {mux,disp} pair is unchanged. When the count reaches SETTLE, sample and go to HELD.
  - HELD: already sampled during this dwell. Any change in the pair goes to SETTLE with count 1, or to WAIT if the new position is blank.
  - In SETTLE, any change in the pair restarts the count at 1, or goes to WAIT if the position is blank.
- **Glyph decode (normalized segments):**
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Any other pattern, including blank 00, is illegal.
- **Sample:**
  - Legal glyph: write the nibble to frame slot p and set `seen[p]`.
  - Illegal glyph: pulse `bad_pattern`, set `err`, and set `seen[p]`.
  - Resampling a slot that is already seen overwrites it. Last sample wins.
- **Frame complete (`seen` = 1111):** clear `seen` and `err` in the same cycle, then apply one of these:
  - `err` set: discard the frame, no `frame_done`, `match_cnt` := 0.
  - Otherwise, pulse `frame_done`, then:
    - if the frame equals `prev_frame`, `match_cnt` := min(`match_cnt`+1, 15);
    - otherwise `match_cnt` := 1;
    - in both cases `prev_frame` := frame.
  - If the resulting `match_cnt` ≥ STABLE_FRAMES, load `digits` from the frame and set `digits_valid`.
- **Arithmetic:** `digits` changes only at a frame completion. Counters saturate and never wrap.
- **Reset:**
  - All outputs go to 0.
  - `seen`, `err`, `match_cnt` and `prev_frame` clear, and the FSM goes to WAIT.
  - Reset during a dwell or part-way through a frame discards all partial state.

## Timing
- Pin-to-register latency is 1 cycle.
- A sample occurs on the cycle the registered pair completes SETTLE identical cycles. The fastest sample is SETTLE+1 cycles after the pins change.
- `frame_done`, the `digits` update, `digits_valid` and `bad_pattern` are all registered. Each asserts on the cycle after the sample that causes it.
- Simultaneous events (illegal glyph completing a frame): `bad_pattern` pulses and the frame is discarded in that same cycle.
- A dwell shorter than SETTLE produces no sample for that position.
- Throughput: one sample per dwell, so one frame per full scan of 4 dwells.

## Structure
- Shared package holds:
  - the glyph constants GLYPH_0…GLYPH_F, shared with the display driver;
  - `NUM_DIGITS` = 4;
  - the FSM state typedef.
- One combinational sub-module, `seg_glyph_decode`: 7-bit pattern in, {legal, nibble[3:0]} out.
- The FSM, counters and frame store stay in `seg_scan_capture`.

## Test plan
- **Clean scan:** default parameters, active-low lines, driver scanning digits 1,2,3,4 with dwell 8 → `digits` = 16'h4321 and `digits_valid` = 1 after the 2nd full scan; `frame_done` pulses once per scan.
- **Short dwell:** dwell 3 with SETTLE=4 → no samples, no `frame_done`, `digits` stays 0.
- **Illegal glyph:** digit 2 shows 7'h00 for one scan within scans of A,b,C,d → `bad_pattern` pulse, that frame discarded, `match_cnt` reset; `digits` becomes 16'hdCbA only after 2 further clean scans.
- **Digit change:** stable 16'h0000, then the driver switches to 16'h0009 → `digits` is still 16'h0000 after the 1st new frame and 16'h0009 after the 2nd.
- **Ghosting:** `mux` = 0000 and `mux` = 0011 between dwells → treated as blank, ignored, no corruption of slots.
- **Mid-frame reset:** `rst` high for 1 cycle after 2 of 4 digits are sampled → all outputs 0 the next cycle; the first `frame_done` comes only after a full new scan.

Source files
------------

// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the seven-segment scan capture block: glyph
// patterns (active-high, bit0 = a ... bit6 = g), digit count and FSM states.
package seg_scan_capture_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    // WAIT: blank position, SETTLE: counting a stable dwell, HELD: dwell already sampled
    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_HELD
    } scan_state_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph-to-nibble decoder. Any pattern outside the sixteen
// hex glyphs (blank included) comes out with legal low.
module seg_glyph_decode
    import seg_scan_capture_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] nibble
);

    // Map each normalized segment pattern back to the hex digit it draws
    always_comb begin
        legal  = 1'b1;
        nibble = 4'h0;
        case (pattern)
            GLYPH_0: nibble = 4'h0;
            GLYPH_1: nibble = 4'h1;
            GLYPH_2: nibble = 4'h2;
            GLYPH_3: nibble = 4'h3;
            GLYPH_4: nibble = 4'h4;
            GLYPH_5: nibble = 4'h5;
            GLYPH_6: nibble = 4'h6;
            GLYPH_7: nibble = 4'h7;
            GLYPH_8: nibble = 4'h8;
            GLYPH_9: nibble = 4'h9;
            GLYPH_A: nibble = 4'hA;
            GLYPH_B: nibble = 4'hB;
            GLYPH_C: nibble = 4'hC;
            GLYPH_D: nibble = 4'hD;
            GLYPH_E: nibble = 4'hE;
            GLYPH_F: nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Receiver for the multiplexed 4-digit seven-segment bus. Samples each
// digit once per stable dwell, assembles frames and publishes a frame on
// digits only after it has repeated for STABLE_FRAMES consecutive scans.
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int SETTLE         = 4,
    parameter int STABLE_FRAMES  = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit POS_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  disp,
    input  logic [3:0]  mux,
    output logic [15:0] digits,
    output logic        digits_valid,
    output logic        frame_done,
    output logic        bad_pattern
);

    localparam logic [7:0] SETTLE_L = 8'(SETTLE);
    localparam logic [3:0] STABLE_L = 4'(STABLE_FRAMES);

    logic [6:0]              disp_r;
    logic [3:0]              mux_r;
    logic [6:0]              seg_n;
    logic [3:0]              pos_n;
    logic [10:0]             pair;
    logic [10:0]             last_pair;
    logic                    pos_valid;
    logic [1:0]              pos_idx;
    logic                    legal;
    logic [3:0]              nibble;

    scan_state_t             state;
    logic [7:0]              cnt;
    logic [15:0]             slots;
    logic [NUM_DIGITS-1:0]   seen;
    logic                    err;
    logic [3:0]              match_cnt;
    logic [15:0]             prev_frame;

    logic                    same;
    logic [7:0]              cnt_eff;
    logic                    do_sample;
    logic [NUM_DIGITS-1:0]   seen_upd;
    logic [15:0]             frame_upd;
    logic                    err_upd;
    logic                    frame_full;
    logic [3:0]              match_upd;

    assign seg_n = SEG_ACTIVE_LOW ? ~disp_r : disp_r;
    assign pos_n = POS_ACTIVE_LOW ? ~mux_r : mux_r;
    assign pair  = {pos_n, seg_n};

    seg_glyph_decode u_decode (
        .pattern (seg_n),
        .legal   (legal),
        .nibble  (nibble)
    );

    // Register the raw bus pins once before any decoding
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_r <= '0;
            mux_r  <= '0;
        end else begin
            disp_r <= disp;
            mux_r  <= mux;
        end
    end

    // Exactly one active select line names a position; anything else is blank
    always_comb begin
        pos_valid = 1'b1;
        pos_idx   = 2'd0;
        case (pos_n)
            4'b0001: pos_idx = 2'd0;
            4'b0010: pos_idx = 2'd1;
            4'b0100: pos_idx = 2'd2;
            4'b1000: pos_idx = 2'd3;
            default: pos_valid = 1'b0;
        endcase
    end

    // Work out this cycle's dwell count, sample decision and frame results
    always_comb begin
        same = (state != ST_WAIT) && (pair == last_pair);
        if (!same)
            cnt_eff = 8'd1;
        else if (cnt == 8'hFF)
            cnt_eff = cnt;
        else
            cnt_eff = cnt + 8'd1;

        // HELD with an unchanged pair must never resample, even if the count saturates at SETTLE
        do_sample = pos_valid && (cnt_eff == SETTLE_L) && !(state == ST_HELD && same);

        seen_upd          = seen;
        seen_upd[pos_idx] = 1'b1;

        frame_upd = slots;
        if (legal)
            frame_upd[{pos_idx, 2'b00} +: 4] = nibble;

        err_upd    = err | ~legal;
        frame_full = &seen_upd;

        if (frame_upd == prev_frame)
            match_upd = (match_cnt == 4'hF) ? 4'hF : match_cnt + 4'd1;
        else
            match_upd = 4'd1;
    end

    // Dwell FSM, frame store and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pair    <= '0;
            state        <= ST_WAIT;
            cnt          <= '0;
            slots        <= '0;
            seen         <= '0;
            err          <= 1'b0;
            match_cnt    <= '0;
            prev_frame   <= '0;
            digits       <= '0;
            digits_valid <= 1'b0;
            frame_done   <= 1'b0;
            bad_pattern  <= 1'b0;
        end else begin
            last_pair   <= pair;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;

            if (!pos_valid) begin
                state <= ST_WAIT;
                cnt   <= '0;
            end else if (state == ST_HELD && same) begin
                state <= ST_HELD;
            end else if (do_sample) begin
                state <= ST_HELD;
                cnt   <= cnt_eff;
            end else begin
                state <= ST_SETTLE;
                cnt   <= cnt_eff;
            end

            if (do_sample) begin
                bad_pattern <= ~legal;
                slots       <= frame_upd;
                if (frame_full) begin
                    seen <= '0;
                    err  <= 1'b0;
                    if (err_upd) begin
                        match_cnt <= '0;
                    end else begin
                        frame_done <= 1'b1;
                        match_cnt  <= match_upd;
                        prev_frame <= frame_upd;
                        if (match_upd >= STABLE_L) begin
                            digits       <= frame_upd;
                            digits_valid <= 1'b1;
                        end
                    end
                end else begin
                    seen <= seen_upd;
                    err  <= err_upd;
                end
            end
        end
    end

endmodule
